multicycle_controller: RTL

- Control FSM for the multicycle RV32I datapath: one shared ALU, one unified instruction/data memory, and the IR, OldPC, Data and ALUOut holding registers.
- Sequences each instruction through fetch, decode, execute, memory and writeback, one step per cycle.
- Stalls on a memory-ready handshake.
- Supports lw, sw, R-type, I-type ALU, beq and jal.
- Flags illegal opcodes and counts retired instructions.

---
 rtl/riscv_pkg.sv | 88 ++++++++
 rtl/alu_decoder.sv | 38 +++
 rtl/multicycle_controller.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I multicycle control path: opcodes, FSM
// states, ALU control encodings, datapath select encodings and ALUOp.
package riscv_pkg;

  // Opcodes handled by the controller
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Controller states
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  // ALUControl encodings
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  // Writeback / PC result select
  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_e;

  // ALU operand A select
  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RD1   = 2'b10
  } alu_src_a_e;

  // ALU operand B select
  typedef enum logic [1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_e;

  // Immediate format select
  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  // Coarse ALU operation class handed to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // Immediate format implied by the opcode; unknown opcodes fall back to I
  function automatic imm_src_e imm_src_of(input logic [6:0] op);
    imm_src_e imm;
    case (op)
      OP_LOAD,
      OP_ITYPE:  imm = IMM_I;
      OP_STORE:  imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
      OP_JAL:    imm = IMM_J;
      default:   imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus instruction fields to
// ALUControl. Shared with the single-cycle core.
module alu_decoder
  import riscv_pkg::*;
(
  input  alu_op_e     alu_op_i,
  input  logic [2:0]  funct3_i,
  input  logic        op_b5_i,
  input  logic        funct7b5_i,
  output alu_ctrl_e   alu_control_o
);

  // Decode ALU function; subtract only for R-type with funct7[5] set
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000: begin
            if (op_b5_i && funct7b5_i) begin
              alu_control_o = ALU_SUB;
            end else begin
              alu_control_o = ALU_ADD;
            end
          end
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I datapath. Steps each instruction
// through fetch/decode/execute/memory/writeback, stalls on mem_ready,
// traps on unknown opcodes and counts retired instructions.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             RegWrite,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret
);

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  instret_q;

  alu_op_e           alu_op_s;
  alu_ctrl_e         alu_control_s;
  result_src_e       result_src_s;
  alu_src_a_e        src_a_s;
  alu_src_b_e        src_b_s;
  logic              adr_src_s;
  logic              mem_write_s;
  logic              ir_write_s;
  logic              pc_write_s;
  logic              reg_write_s;
  logic              retire_s;

  // State register with synchronous reset back to fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
    end else if (retire_s) begin
      instret_q <= instret_q + CNT_W'(1);
    end else begin
      instret_q <= instret_q;
    end
  end

  // Next-state and Moore output decode; only the enables look at inputs
  always_comb begin
    state_d      = state_q;
    alu_op_s     = ALUOP_ADD;
    result_src_s = RES_ALUOUT;
    src_a_s      = SRCA_PC;
    src_b_s      = SRCB_RD2;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    retire_s     = 1'b0;
    case (state_q)
      S_FETCH: begin
        src_b_s      = SRCB_FOUR;
        result_src_s = RES_ALURESULT;
        ir_write_s   = mem_ready;
        pc_write_s   = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // OldPC + imm lands in ALUOut as the branch/jump target
        src_a_s = SRCA_OLDPC;
        src_b_s = SRCB_IMM;
        case (op)
          OP_LOAD,
          OP_STORE:  state_d = S_MEMADR;
          OP_RTYPE:  state_d = S_EXECUTER;
          OP_ITYPE:  state_d = S_EXECUTEI;
          OP_BRANCH: state_d = S_BEQ;
          OP_JAL:    state_d = S_JAL;
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        src_a_s = SRCA_RD1;
        src_b_s = SRCB_IMM;
        if (op[5]) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        adr_src_s = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        if (mem_ready) begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_MEMWB: begin
        result_src_s = RES_DATA;
        reg_write_s  = 1'b1;
        state_d      = S_FETCH;
        retire_s     = 1'b1;
      end
      S_EXECUTER: begin
        src_a_s  = SRCA_RD1;
        src_b_s  = SRCB_RD2;
        alu_op_s = ALUOP_FUNCT;
        state_d  = S_ALUWB;
      end
      S_EXECUTEI: begin
        src_a_s  = SRCA_RD1;
        src_b_s  = SRCB_IMM;
        alu_op_s = ALUOP_FUNCT;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
        retire_s    = 1'b1;
      end
      S_BEQ: begin
        src_a_s    = SRCA_RD1;
        src_b_s    = SRCB_RD2;
        alu_op_s   = ALUOP_SUB;
        pc_write_s = zero;
        state_d    = S_FETCH;
        retire_s   = 1'b1;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while OldPC + 4 is formed for rd
        src_a_s    = SRCA_OLDPC;
        src_b_s    = SRCB_FOUR;
        pc_write_s = 1'b1;
        state_d    = S_ALUWB;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op_s),
    .funct3_i      (funct3),
    .op_b5_i       (op[5]),
    .funct7b5_i    (funct7b5),
    .alu_control_o (alu_control_s)
  );

  // Enables and the retire pulse are held low throughout a reset cycle
  assign PCWrite    = pc_write_s  & ~reset;
  assign IRWrite    = ir_write_s  & ~reset;
  assign RegWrite   = reg_write_s & ~reset;
  assign MemWrite   = mem_write_s & ~reset;
  assign instr_done = retire_s    & ~reset;

  assign AdrSrc     = adr_src_s;
  assign ResultSrc  = result_src_s;
  assign ALUSrcA    = src_a_s;
  assign ALUSrcB    = src_b_s;
  assign ImmSrc     = imm_src_of(op);
  assign ALUControl = alu_control_s;
  assign illegal    = (state_q == S_TRAP);
  assign instret    = instret_q;

endmodule
